// File: rtl/pwm_demod_pkg.sv
// Shared types and constants for the pulse-width symbol demodulator.
package pwm_demod_pkg;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        HIGH  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input register(s) for sig_in plus rise/fall detection. Synchroniser depth is
// 2 flops when PWM_DEMOD_SYNC2_EN is defined, otherwise a single register.
module pwm_edge_sync
    import pwm_demod_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_q,
    output logic rise,
    output logic fall,
    output logic primed
);

    logic sig_q_r;
    logic sig_prev_r;

`ifdef PWM_DEMOD_SYNC2_EN
    logic       meta_r;
    logic [1:0] vld_r;

    // Two-stage synchroniser; vld_r tracks when sig_q_r holds a real line sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r     <= 1'b0;
            sig_q_r    <= 1'b0;
            sig_prev_r <= 1'b0;
            vld_r      <= 2'b00;
        end else begin
            meta_r     <= sig_in;
            sig_q_r    <= meta_r;
            sig_prev_r <= sig_q_r;
            vld_r      <= {vld_r[0], 1'b1};
        end
    end

    assign primed = vld_r[1];
`else
    logic vld_r;

    // Single input register; vld_r tracks when sig_q_r holds a real line sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q_r    <= 1'b0;
            sig_prev_r <= 1'b0;
            vld_r      <= 1'b0;
        end else begin
            sig_q_r    <= sig_in;
            sig_prev_r <= sig_q_r;
            vld_r      <= 1'b1;
        end
    end

    assign primed = vld_r;
`endif

    assign sig_q = sig_q_r;
    assign rise  = sig_q_r & ~sig_prev_r;
    assign fall  = ~sig_q_r & sig_prev_r;

endmodule

// File: rtl/pwm_symbol_demod.sv
// Pulse-width demodulator: classifies high pulses as bits or errors and packs
// bits MSB-first into words. PWM_DEMOD_SYNC2_EN adds one synchroniser stage.
module pwm_symbol_demod
    import pwm_demod_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int MIN_W  = 2,
    parameter int THRESH = 11,
    parameter int MAX_W  = 200,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_in,
    output logic              bit_data,
    output logic              bit_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic              sig_q_s;
    logic              rise_s;
    logic              fall_s;
    logic              primed_s;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              accept_s;
    logic              bit_s;
    logic              err_s;
    logic [1:0]        err_code_s;

    logic [BC_W-1:0]   bit_cnt_r;
    logic [WORD_W-2:0] shreg_r;
    logic [WORD_W-1:0] word_next_s;

    logic              bit_data_r;
    logic              bit_valid_r;
    logic [WORD_W-1:0] word_data_r;
    logic              word_valid_r;
    logic              err_valid_r;
    logic [1:0]        err_code_r;
    logic              busy_r;

    pwm_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .sig_q  (sig_q_s),
        .rise   (rise_s),
        .fall   (fall_s),
        .primed (primed_s)
    );

    // FSM state and pulse-width counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DRAIN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, counter update and per-pulse decision.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        bit_s        = 1'b0;
        err_s        = 1'b0;
        err_code_s   = ERR_NONE;
        case (state_r)
            DRAIN: begin
                cnt_next_s = {CNT_W{1'b0}};
                // primed keeps the reset value of sig_q from being mistaken for a low line
                if (primed_s && !sig_q_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            IDLE: begin
                if (rise_s) begin
                    state_next_s = HIGH;
                    cnt_next_s   = CNT_W'(1);
                end else begin
                    state_next_s = IDLE;
                end
            end
            HIGH: begin
                // In HIGH the previous sample is always 1, so fall equals sig_q==0
                if (fall_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                    if (cnt_r < CNT_W'(MIN_W)) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_SHORT;
                    end else begin
                        accept_s = 1'b1;
                        bit_s    = (cnt_r <= CNT_W'(THRESH));
                    end
                end else if (cnt_r < CNT_W'(MAX_W)) begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end else begin
                    err_s        = 1'b1;
                    err_code_s   = ERR_LONG;
                    state_next_s = DRAIN;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_next_s = DRAIN;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign word_next_s = {shreg_r, bit_s};

    // Registered strobes plus MSB-first word assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_data_r   <= 1'b0;
            bit_valid_r  <= 1'b0;
            word_data_r  <= {WORD_W{1'b0}};
            word_valid_r <= 1'b0;
            err_valid_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
            busy_r       <= 1'b0;
            bit_cnt_r    <= {BC_W{1'b0}};
            shreg_r      <= {(WORD_W-1){1'b0}};
        end else begin
            bit_data_r   <= accept_s & bit_s;
            bit_valid_r  <= accept_s;
            err_valid_r  <= err_s;
            err_code_r   <= err_code_s;
            busy_r       <= (state_next_s == HIGH);
            word_valid_r <= 1'b0;
            if (accept_s) begin
                shreg_r <= word_next_s[WORD_W-2:0];
                if (bit_cnt_r == BC_W'(WORD_W - 1)) begin
                    word_data_r  <= word_next_s;
                    word_valid_r <= 1'b1;
                    bit_cnt_r    <= {BC_W{1'b0}};
                end else begin
                    bit_cnt_r <= bit_cnt_r + BC_W'(1);
                end
            end else if (err_s) begin
                bit_cnt_r <= {BC_W{1'b0}};
                shreg_r   <= {(WORD_W-1){1'b0}};
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign bit_data   = bit_data_r;
    assign bit_valid  = bit_valid_r;
    assign word_data  = word_data_r;
    assign word_valid = word_valid_r;
    assign err_valid  = err_valid_r;
    assign err_code   = err_code_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_pwm_symbol_demod.sv
// Directed bench for pwm_symbol_demod: table of single pulses plus multi-cycle
// sequences (stuck-high reset, timeout, glitch word discard, mid-pulse reset).
module tb_pwm_symbol_demod;

`ifdef PWM_DEMOD_SYNC2_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_in = 1'b1;
    logic       bit_data;
    logic       bit_valid;
    logic [7:0] word_data;
    logic       word_valid;
    logic       err_valid;
    logic [1:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    pwm_symbol_demod dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .bit_data   (bit_data),
        .bit_valid  (bit_valid),
        .word_data  (word_data),
        .word_valid (word_valid),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .busy       (busy)
    );

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int         n_bit = 0, n_err = 0, n_word = 0, n_both = 0, n_orphan = 0;
    logic       last_bit = 1'b0;
    logic [1:0] last_code = 2'b00;
    logic [7:0] last_word = 8'h00;
    int         last_bit_edge = 0, last_err_edge = 0, last_word_edge = 0;

    always @(negedge clk) begin
        if (bit_valid) begin
            n_bit         <= n_bit + 1;
            last_bit      <= bit_data;
            last_bit_edge <= edges;
        end
        if (err_valid) begin
            n_err         <= n_err + 1;
            last_code     <= err_code;
            last_err_edge <= edges;
        end
        if (word_valid) begin
            n_word         <= n_word + 1;
            last_word      <= word_data;
            last_word_edge <= edges;
            if (!bit_valid) n_orphan <= n_orphan + 1;
        end
        if (bit_valid && err_valid) n_both <= n_both + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rise_edge = 0, fall_edge = 0;
    int b0, e0, w0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {20'd0, bit_data, bit_valid, word_data, word_valid, err_valid, err_code, busy},
              32'd0);
    endtask

    task automatic pulse(input int w, input int gap);
        sig_in    = 1'b1;
        rise_edge = edges;
        repeat (w) @(negedge clk);
        sig_in    = 1'b0;
        fall_edge = edges;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) pulse(b[i] ? 4 : 20, 5);
    endtask

    task automatic snap();
        b0 = n_bit;
        e0 = n_err;
        w0 = n_word;
    endtask

    typedef struct {
        int         width;
        logic       is_err;
        logic [1:0] exp_val;
        logic       chk_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{5,   1'b0, 2'b01, 1'b1};
        vecs[1] = '{11,  1'b0, 2'b01, 1'b1};
        vecs[2] = '{12,  1'b0, 2'b00, 1'b1};
        vecs[3] = '{2,   1'b0, 2'b01, 1'b1};
        vecs[4] = '{1,   1'b1, 2'b01, 1'b1};
        vecs[5] = '{13,  1'b0, 2'b00, 1'b1};
        vecs[6] = '{200, 1'b0, 2'b00, 1'b1};
        vecs[7] = '{201, 1'b1, 2'b10, 1'b0};
        vecs[8] = '{4,   1'b0, 2'b01, 1'b1};

        // Line high through reset and for 20 cycles after: nothing decoded.
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("stuck_high_no_bit", n_bit, 0);
        check("stuck_high_no_err", n_err, 0);
        check("stuck_high_busy", {31'd0, busy}, 0);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        pulse(5, 5);
        check("first_pulse_count", n_bit, 1);
        check("first_pulse_bit", {31'd0, last_bit}, 1);
        check("first_pulse_latency", last_bit_edge - fall_edge, LAT);

        for (int i = 0; i < 9; i++) begin
            snap();
            pulse(vecs[i].width, 5);
            if (vecs[i].is_err) begin
                check($sformatf("vec%0d_err_count", i), n_err - e0, 1);
                check($sformatf("vec%0d_no_bit", i), n_bit - b0, 0);
                check($sformatf("vec%0d_code", i), {30'd0, last_code}, {30'd0, vecs[i].exp_val});
                if (vecs[i].chk_lat)
                    check($sformatf("vec%0d_latency", i), last_err_edge - fall_edge, LAT);
            end else begin
                check($sformatf("vec%0d_bit_count", i), n_bit - b0, 1);
                check($sformatf("vec%0d_no_err", i), n_err - e0, 0);
                check($sformatf("vec%0d_bit", i), {31'd0, last_bit}, {31'd0, vecs[i].exp_val[0]});
                if (vecs[i].chk_lat)
                    check($sformatf("vec%0d_latency", i), last_bit_edge - fall_edge, LAT);
            end
        end

        // 250-cycle high: timeout fires while still high, the fall is silent.
        snap();
        pulse(250, 5);
        check("long_err_count", n_err - e0, 1);
        check("long_err_code", {30'd0, last_code}, 32'd2);
        check("long_err_timing", last_err_edge - rise_edge, 200 + LAT);
        check("long_no_bit", n_bit - b0, 0);
        snap();
        pulse(4, 5);
        check("after_long_bit_count", n_bit - b0, 1);
        check("after_long_bit", {31'd0, last_bit}, 1);

        // Three bits, a glitch, then 0xA5: glitch must discard the partial word.
        snap();
        pulse(4, 5);
        pulse(20, 5);
        pulse(4, 5);
        pulse(1, 5);
        check("glitch_err", n_err - e0, 1);
        check("glitch_code", {30'd0, last_code}, 32'd1);
        send_byte(8'hA5);
        check("word_count", n_word - w0, 1);
        check("word_value", {24'd0, last_word}, 32'h0000_00A5);
        check("word_with_last_bit", last_word_edge, last_bit_edge);
        repeat (10) @(negedge clk);
        check("word_held", {24'd0, word_data}, 32'h0000_00A5);

        // Two bits of a partial word, then reset mid-pulse at cnt=7.
        pulse(4, 5);
        pulse(4, 5);
        sig_in = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_mid_pulse", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset_outputs");
        rst = 1'b0;
        snap();
        repeat (30) @(negedge clk);
        check("post_reset_no_bit", n_bit - b0, 0);
        check("post_reset_no_err", n_err - e0, 0);
        check("post_reset_busy", {31'd0, busy}, 0);
        sig_in = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_fall_silent", (n_bit - b0) + (n_err - e0), 0);
        send_byte(8'h3C);
        check("post_reset_word_count", n_word - w0, 1);
        check("post_reset_word", {24'd0, last_word}, 32'h0000_003C);

        check("never_bit_and_err", n_both, 0);
        check("word_only_with_bit", n_orphan, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
